// File: rtl/pre_comm_router.sv
// pre_comm_router: per-channel FIFOs steering requests to two round-robin arbitrated commutator pipelines.
module pre_comm_router #(
  parameter int nIN   = 8,
  parameter int nOUT  = 52,
  parameter int wD    = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [nIN-1:0]           req_in,
  input  logic [wD*nIN-1:0]        data_in,
  input  logic [$clog2(nOUT)*nIN-1:0] addr_in,
  input  logic [1:0]               ready_out,
  output logic [1:0]               valid_out,
  output logic [2*wD-1:0]          data_out,
  output logic [2*$clog2(nOUT/2)-1:0] addr_out,
  output logic [2*$clog2(nIN)-1:0] src_out,
  output logic [nIN-1:0]           ovf
);
  localparam int wA_OUT = $clog2(nOUT);
  localparam int nCH    = nOUT / 2;
  localparam int wA_CH  = $clog2(nCH);
  localparam int wIN    = $clog2(nIN);
  localparam int wP     = $clog2(DEPTH);
  localparam int wE     = wA_OUT + wD;

  logic [wE-1:0]  mem [nIN][DEPTH];
  logic [wP-1:0]  rd [nIN];
  logic [wP-1:0]  wr [nIN];
  logic [wP:0]    cnt [nIN];
  logic [wE-1:0]  head [nIN];
  logic [nIN-1:0] want [2];
  logic [nIN-1:0] push, pop;
  logic [wIN-1:0] rr [2];
  logic [wIN-1:0] gnt [2];
  logic [1:0]     gnt_v, out_free, fire;

  always_comb begin
    for (int i = 0; i < nIN; i++) begin
      head[i]    = mem[i][rd[i]];
      want[0][i] = (cnt[i] != '0) && !head[i][wD+wA_CH];
      want[1][i] = (cnt[i] != '0) && head[i][wD+wA_CH];
    end
  end

  // Round-robin search starts at rr[p]; the first requesting head wins.
  always_comb begin
    int j;
    pop = '0;
    for (int p = 0; p < 2; p++) begin
      gnt_v[p] = 1'b0;
      gnt[p]   = '0;
      for (int k = 0; k < nIN; k++) begin
        j = (int'(rr[p]) + k) % nIN;
        if (!gnt_v[p] && want[p][wIN'(j)]) begin
          gnt_v[p] = 1'b1;
          gnt[p]   = wIN'(j);
        end
      end
      out_free[p] = !valid_out[p] || ready_out[p];
      fire[p]     = gnt_v[p] && out_free[p];
      if (fire[p]) pop[gnt[p]] = 1'b1;
    end
  end

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  always_comb begin
    for (int i = 0; i < nIN; i++)
      push[i] = req_in[i] && (cnt[i] != (wP+1)'(DEPTH) || pop[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= '0;
      for (int i = 0; i < nIN; i++) begin
        rd[i]  <= '0;
        wr[i]  <= '0;
        cnt[i] <= '0;
      end
    end else begin
      ovf <= ovf | (req_in & ~push);
      for (int i = 0; i < nIN; i++) begin
        if (push[i]) begin
          mem[i][wr[i]] <= {addr_in[i*wA_OUT +: wA_OUT], data_in[i*wD +: wD]};
          wr[i]         <= wr[i] + 1'b1;
        end
        if (pop[i]) rd[i] <= rd[i] + 1'b1;
        cnt[i] <= cnt[i] + (wP+1)'(push[i]) - (wP+1)'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= '0;
      data_out  <= '0;
      addr_out  <= '0;
      src_out   <= '0;
      rr[0]     <= '0;
      rr[1]     <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (fire[p]) begin
          valid_out[p]               <= 1'b1;
          data_out[p*wD +: wD]       <= head[gnt[p]][wD-1:0];
          addr_out[p*wA_CH +: wA_CH] <= head[gnt[p]][wD +: wA_CH];
          src_out[p*wIN +: wIN]      <= gnt[p];
          rr[p]                      <= (gnt[p] == wIN'(nIN-1)) ? '0 : gnt[p] + 1'b1;
        end else if (ready_out[p]) begin
          valid_out[p] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pre_comm_router.sv
// tb_pre_comm_router: directed vectors with hand-computed expectations for pre_comm_router.
module tb_pre_comm_router;
  localparam int NI = 8;
  localparam int WD = 25;
  localparam int WA = 6;
  localparam int WC = 5;
  localparam int WI = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NI-1:0]   req_in = '0;
  logic [WD*NI-1:0] data_in = '0;
  logic [WA*NI-1:0] addr_in = '0;
  logic [1:0]      ready_out = 2'b11;
  logic [1:0]      valid_out;
  logic [2*WD-1:0] data_out;
  logic [2*WC-1:0] addr_out;
  logic [2*WI-1:0] src_out;
  logic [NI-1:0]   ovf;
  int total = 0;
  int bad = 0;

  pre_comm_router #(.nIN(NI), .nOUT(52), .wD(WD), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in), .addr_in(addr_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .addr_out(addr_out), .src_out(src_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input int a, input int d);
    req_in[ch] = 1'b1;
    addr_in[ch*WA +: WA] = WA'(a);
    data_in[ch*WD +: WD] = WD'(d);
  endtask

  function automatic logic [31:0] dat(input int p);
    return 32'(data_out[p*WD +: WD]);
  endfunction

  function automatic logic [31:0] adr(input int p);
    return 32'(addr_out[p*WC +: WC]);
  endfunction

  function automatic logic [31:0] src(input int p);
    return 32'(src_out[p*WI +: WI]);
  endfunction

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_addr", 32'(addr_out), 0);
    chk("rst_src", 32'(src_out), 0);

    put(3, 33, 'h1ABCDE);
    tick();
    req_in = '0;
    chk("t1_lat1", 32'(valid_out), 0);
    tick();
    chk("t1_valid", 32'(valid_out), 2);
    chk("t1_addr", adr(1), 1);
    chk("t1_data", dat(1), 'h1ABCDE);
    chk("t1_src", src(1), 3);
    tick();
    chk("t1_idle", 32'(valid_out), 0);

    put(2, 4, 'h102);
    put(5, 4, 'h105);
    put(7, 4, 'h107);
    tick();
    req_in = '0;
    tick();
    chk("t2_v2", 32'(valid_out), 1);
    chk("t2_s2", src(0), 2);
    chk("t2_d2", dat(0), 'h102);
    tick();
    chk("t2_s5", src(0), 5);
    chk("t2_d5", dat(0), 'h105);
    tick();
    chk("t2_s7", src(0), 7);
    chk("t2_v7", 32'(valid_out), 1);
    tick();
    chk("t2_idle", 32'(valid_out), 0);
    put(0, 4, 'h200);
    put(5, 4, 'h205);
    tick();
    req_in = '0;
    tick();
    chk("t2_r0", src(0), 0);
    tick();
    chk("t2_r5", src(0), 5);
    chk("t2_r5d", dat(0), 'h205);
    tick();
    chk("t2_ridle", 32'(valid_out), 0);

    put(1, 10, 'h301);
    put(6, 40, 'h306);
    tick();
    req_in = '0;
    tick();
    chk("t3_valid", 32'(valid_out), 3);
    chk("t3_a0", adr(0), 10);
    chk("t3_s0", src(0), 1);
    chk("t3_a1", adr(1), 8);
    chk("t3_s1", src(1), 6);
    tick();
    chk("t3_idle", 32'(valid_out), 0);

    ready_out = 2'b10;
    put(4, 4, 'hA);
    tick();
    put(4, 4, 'hB);
    tick();
    put(4, 4, 'hC);
    tick();
    req_in = '0;
    chk("t4_hold_v", 32'(valid_out), 1);
    chk("t4_hold_d", dat(0), 'hA);
    tick();
    tick();
    chk("t4_stable_v", 32'(valid_out), 1);
    chk("t4_stable_d", dat(0), 'hA);
    chk("t4_stable_s", src(0), 4);
    ready_out = 2'b11;
    tick();
    chk("t4_b", dat(0), 'hB);
    tick();
    chk("t4_c", dat(0), 'hC);
    chk("t4_cv", 32'(valid_out), 1);
    tick();
    chk("t4_idle", 32'(valid_out), 0);

    ready_out = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      put(0, 4, k);
      tick();
    end
    req_in = '0;
    chk("t5_ovf", 32'(ovf), 1);
    chk("t5_head", dat(0), 1);
    tick();
    chk("t5_hold", dat(0), 1);
    ready_out = 2'b11;
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("t5_word", dat(0), 32'(k));
      chk("t5_wv", 32'(valid_out), 1);
    end
    tick();
    chk("t5_drain", 32'(valid_out), 0);
    chk("t5_ovf_sticky", 32'(ovf), 1);

    ready_out = 2'b00;
    for (int k = 0; k < 3; k++) begin
      put(2, 4, 'h400 + k);
      put(3, 40, 'h500 + k);
      tick();
    end
    req_in = '0;
    chk("t6_loaded", 32'(valid_out), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", 32'(valid_out), 0);
    chk("t6_ovf", 32'(ovf), 0);
    chk("t6_data", 32'(data_out), 0);
    ready_out = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_nostale", 32'(valid_out), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
